// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer of the byte-wide async FIFO. It runs entirely in the FIFO
// read clock domain. It pops DATA_WIDTH-bit entries and packs PACK_RATIO
// consecutive entries into one wide word. The first popped entry goes into the
// least-significant slice. Each word is offered on a valid/ready stream.
// Popping is gated so that a byte is only fetched when there is room to store
// it. The block therefore never overfetches while it holds a word.
//
// Optional feature (define FIFO_PACK_FLUSH_EN):
//   A partially filled word is flushed downstream after FLUSH_CYCLES idle
//   cycles. out_count then reports the number of valid bytes, and the unfilled
//   upper slices are zero. Without the macro, a partial word waits for more
//   bytes indefinitely.
//
// Ports:
//   rd_clk      in   FIFO read-domain clock; all state changes on its rising edge
//   rst         in   synchronous, active-high reset
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after an accepted pop
//   fifo_rd_en  out  FIFO pop request
//   out_data    out  packed word (first-popped byte in the LSB slice)
//   out_count   out  number of valid bytes in out_data
//   out_valid   out  packed word available
//   out_ready   in   downstream accepts the word
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
  parameter int DATA_WIDTH   = 8,
  parameter int PACK_RATIO   = 4,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                             rd_clk,
  input  logic                             rst,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_dout,
  output logic                             fifo_rd_en,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
  output logic [$clog2(PACK_RATIO):0]      out_count,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int CNT_W  = $clog2(PACK_RATIO) + 1;
  localparam int WORD_W = DATA_WIDTH * PACK_RATIO;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                inflight_q, inflight_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                valid_q, valid_d;
  logic                flush_fire;

`ifdef FIFO_PACK_FLUSH_EN
  localparam int IDLE_W = $clog2(FLUSH_CYCLES + 1);

  logic [IDLE_W-1:0] idle_q;
  logic              idle_cond;

  // Idle means a partial word is held and no byte is arriving this cycle.
  assign idle_cond  = (state_q == FILL) && (cnt_q != '0) &&
                      (cnt_q < CNT_W'(PACK_RATIO)) && !inflight_q;
  // Fires on the cycle whose closing edge brings the idle count to FLUSH_CYCLES.
  assign flush_fire = idle_cond && (idle_q == IDLE_W'(FLUSH_CYCLES - 1));

  // Any capture, or leaving FILL, breaks the idle run and clears the counter.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (idle_cond) begin
      idle_q <= idle_q + IDLE_W'(1);
    end else begin
      idle_q <= '0;
    end
  end
`else
  assign flush_fire = 1'b0;
`endif

  // The occupancy term counts the byte already on its way. With it, the slots
  // left can never be oversubscribed, so cnt stops at PACK_RATIO. A flush
  // blocks popping on its own cycle, so no byte arrives after the word is
  // frozen.
  assign fifo_rd_en = !rst && (state_q == FILL) && !fifo_empty && !flush_fire &&
                      ((cnt_q + CNT_W'(inflight_q)) < CNT_W'(PACK_RATIO));

  // NOTE: every variable gets its hold value first, so no path through the
  // case leaves one unassigned. This keeps the process free of inferred latches.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    count_d    = count_q;
    valid_d    = valid_q;
    inflight_d = fifo_rd_en;

    case (state_q)
      FILL: begin
        if (inflight_q) begin
          data_d[DATA_WIDTH*int'(cnt_q) +: DATA_WIDTH] = fifo_dout;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(PACK_RATIO - 1)) begin
            valid_d = 1'b1;
            count_d = CNT_W'(PACK_RATIO);
            state_d = HOLD;
          end
        end else if (flush_fire) begin
          valid_d = 1'b1;
          count_d = cnt_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // out_valid is high exactly while in HOLD, so out_ready is a handshake here.
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = '0;
          data_d  = '0;
          count_d = '0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: state registers use non-blocking assignments. All flops then sample
  // the pre-edge values, whatever order the simulator evaluates them in.
  // NOTE: the data register is reset along with the control state. out_data is
  // a visible output and must read zero after reset.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      data_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      data_q     <= data_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_count = count_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_packer
//
// Directed plus randomized bench for fifo_rd_packer. A queue models the FIFO
// contents behind the DUT's read port. A second queue holds the bytes expected
// downstream. Each accepted word is compared with the next PACK_RATIO expected
// bytes, packed LSB-first. Build with +define+FIFO_PACK_FLUSH_EN to exercise
// the flush path.
// -----------------------------------------------------------------------------
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int FC = 16;
  localparam int WW = DW * PR;
  localparam int CW = $clog2(PR) + 1;

  logic          rd_clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_rd_en;
  logic [WW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_valid;
  logic          out_ready;

  always #5 rd_clk = ~rd_clk;

  fifo_rd_packer #(
    .DATA_WIDTH  (DW),
    .PACK_RATIO  (PR),
    .FLUSH_CYCLES(FC)
  ) dut (
    .rd_clk    (rd_clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .out_data  (out_data),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] fifo_q[$];   // bytes still inside the modelled FIFO
  logic [DW-1:0] exp_q[$];    // bytes pushed but not yet delivered downstream
  int            accept_cyc[$];

  int            cyc   = 0;
  int            pops  = 0;
  int            words = 0;
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_data;
  logic [CW-1:0] prev_count;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle. Outputs are sampled at the falling edge. The FIFO model
  // and inputs are updated 1 time unit after the rising edge.
  task automatic cycle();
    logic          pop;
    logic          acc;
    logic [WW-1:0] ew;
    int            n;
    @(negedge rd_clk);
    pop = fifo_rd_en && !fifo_empty;
    if (fifo_empty) check("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
    if (out_valid)  check("rd_en_while_holding", 64'(fifo_rd_en), 64'd0);
    if (prev_hold) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data",  64'(out_data),  64'(prev_data));
      check("hold_count", 64'(out_count), 64'(prev_count));
    end
    acc = out_valid && out_ready;
    if (acc) begin
      n  = (exp_q.size() >= PR) ? PR : exp_q.size();
      ew = '0;
      for (int i = 0; i < n; i++) ew[i*DW +: DW] = exp_q.pop_front();
      check("word_data",  64'(out_data),  64'(ew));
      check("word_count", 64'(out_count), 64'(n));
      words++;
      accept_cyc.push_back(cyc);
    end
    prev_hold  = out_valid && !out_ready;
    prev_data  = out_data;
    prev_count = out_count;
    @(posedge rd_clk);
    #1;
    cyc++;
    if (pop) begin
      fifo_dout = fifo_q.pop_front();
      pops++;
    end else begin
      fifo_dout = DW'($urandom);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge rd_clk);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    @(posedge rd_clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_count", 64'(out_count), 64'd0);
    rst        = 1'b0;
    prev_hold  = 1'b0;
    exp_q.delete();
    fifo_dout  = DW'($urandom);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    int w0;
    int p0;
    int k;
    int pushed;
    int gap;
    logic saw;

    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    out_ready  = 1'b0;
    do_reset();

    // Full pack: one word, exactly four pops.
    out_ready = 1'b1;
    w0 = words; p0 = pops;
    push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3);
    run(12);
    check("full_words", 64'(words - w0), 64'd1);
    check("full_pops",  64'(pops - p0),  64'd4);

    // Backpressure: first word held stable while the second stays in the FIFO.
    out_ready = 1'b0;
    w0 = words;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    run(20);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_data",  64'(out_data),  64'h0000_0000_A3A2_A1A0);
    check("bp_count", 64'(out_count), 64'd4);
    out_ready = 1'b1;
    run(20);
    check("bp_words", 64'(words - w0), 64'd2);

    // Empty gaps between bytes only stall popping.
    w0 = words;
    for (int i = 0; i < 4; i++) begin
      push(8'hB0 + 8'(i));
      run(7);
    end
    run(5);
    check("gap_words", 64'(words - w0), 64'd1);

    // Reset mid-fill discards the partial word.
    p0 = pops;
    push(8'hC0); push(8'hC1);
    run(6);
    check("c_pops",  64'(pops - p0), 64'd2);
    check("c_valid", 64'(out_valid), 64'd0);
    do_reset();
    w0 = words;
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    run(12);
    check("d_words", 64'(words - w0), 64'd1);

    // Partial word: flushed after the idle timeout, or waits for more bytes.
`ifdef FIFO_PACK_FLUSH_EN
    out_ready = 1'b0;
    push(8'hE0); push(8'hE1); push(8'hE2);
    k = 0;
    while (!out_valid && k < 80) begin
      cycle();
      k++;
    end
    check("flush_valid",   64'(out_valid), 64'd1);
    check("flush_not_early", 64'(k >= FC), 64'd1);
    check("flush_data",    64'(out_data),  64'h0000_0000_00E2_E1E0);
    check("flush_count",   64'(out_count), 64'd3);
    w0 = words;
    out_ready = 1'b1;
    run(3);
    check("flush_words", 64'(words - w0), 64'd1);
`else
    out_ready = 1'b1;
    push(8'hE0); push(8'hE1); push(8'hE2);
    saw = 1'b0;
    repeat (100) begin
      cycle();
      if (out_valid) saw = 1'b1;
    end
    check("no_flush", 64'(saw), 64'd0);
    w0 = words;
    push(8'hE3);
    run(10);
    check("e_words", 64'(words - w0), 64'd1);
`endif

    // Twelve queued bytes with ready high: three words at the minimum period.
    out_ready = 1'b1;
    w0 = words;
    accept_cyc.delete();
    for (int i = 0; i < 12; i++) push(8'h10 + 8'(i));
    run(30);
    check("twelve_words", 64'(words - w0), 64'd3);
    if (accept_cyc.size() == 3) begin
      check("period_1", 64'(accept_cyc[1] - accept_cyc[0]), 64'(PR + 2));
      check("period_2", 64'(accept_cyc[2] - accept_cyc[1]), 64'(PR + 2));
    end else begin
      check("period_accepts", 64'(accept_cyc.size()), 64'd3);
    end

    // Randomized traffic and backpressure. Push gaps stay well below the flush
    // timeout, so only full words are expected.
    pushed = 0;
    gap    = 0;
    repeat (400) begin
      if ($urandom_range(0, 1) == 1 || gap >= 5) begin
        push(DW'($urandom));
        pushed++;
        gap = 0;
      end else begin
        gap++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    while ((pushed % PR) != 0) begin
      push(DW'($urandom));
      pushed++;
    end
    out_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      cycle();
      k++;
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
    run(3);
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_fifo",  64'(fifo_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the 8-bit async FIFO, running entirely in the FIFO read clock domain.
- Pops bytes through the FIFO's empty/rd_en/dout interface and packs PACK_RATIO consecutive bytes into one wide word.
- Presents each packed word on a valid/ready stream to the downstream datapath.
- Owns all FIFO read pacing, so it never overfetches while holding a word.

Parameters:
- DATA_WIDTH, 8, width of one FIFO entry.
- PACK_RATIO, 4, FIFO entries per output word; must be ≥2.
- FLUSH_CYCLES, 16, idle cycles before a partial word is flushed (used only with FIFO_PACK_FLUSH_EN).

Ports:
- rd_clk  input  1  FIFO read-domain clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- fifo_empty  input  1  empty flag from the FIFO read side.
- fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted pop.
- fifo_rd_en  output  1  FIFO pop request.
- out_data  output  DATA_WIDTH*PACK_RATIO  packed word; first-popped byte goes in the least-significant slice.
- out_count  output  $clog2(PACK_RATIO)+1  number of valid bytes in out_data.
- out_valid  output  1  packed word available.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Interface decision: single clock rd_clk; reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_count=0, internal cnt=0, inflight=0, state FILL.
  - fifo_rd_en is 0 while rst is high.
  - A byte in flight at reset is discarded.
  - Any partial word is discarded; reset has no output side effect.
- FIFO timing: a pop is accepted at a rd_clk edge where fifo_rd_en=1 and fifo_empty=0. fifo_dout carries that byte during the following cycle.
- inflight register: set to the accepted-pop condition at each edge, so it marks a byte present on fifo_dout.
- fifo_rd_en (combinational from registers and fifo_empty): state==FILL && !fifo_empty && (cnt + inflight < PACK_RATIO). This guarantees no byte is popped that cannot be stored.
- Capture: at each edge with inflight=1, fifo_dout is written to slice cnt of the data register and cnt increments.
- State FILL:
  - When a capture makes cnt reach PACK_RATIO, out_valid goes to 1 at that same edge, with out_count=PACK_RATIO, and the state moves to HOLD.
- State HOLD:
  - out_valid, out_data and out_count are held stable, and fifo_rd_en=0, until out_ready=1.
  - At the edge with out_valid && out_ready: out_valid→0, cnt→0, data register cleared, state→FILL.
  - Popping resumes in the cycle after the handshake.
- Latency and throughput: out_valid rises at the edge ending the cycle in which the last byte is on fifo_dout. Minimum period is PACK_RATIO+2 cycles per word with out_ready tied high.
- fifo_empty toggling mid-fill only stalls popping. Partial state is retained indefinitely unless the optional feature is enabled.
- out_ready is ignored while out_valid=0.
- Wrap of cnt is impossible: the fifo_rd_en gating caps cnt at PACK_RATIO.

Optional Feature:
- Macro: FIFO_PACK_FLUSH_EN.
- Defined:
  - An idle counter runs in FILL while 0<cnt<PACK_RATIO and inflight=0. It is reset by any capture.
  - When it reaches FLUSH_CYCLES, the block enters HOLD with out_valid=1 and out_count=cnt. Unfilled upper slices are 0.
  - Flushing never happens when cnt=0.
- Not defined:
  - No counter logic exists and out_count is always PACK_RATIO when valid.
  - Partial words wait for more bytes.

Test Plan:
- Full pack: push A0,A1,A2,A3 into the FIFO, out_ready=1 → one word out_data=32'hA3A2A1A0, out_count=4. out_valid high exactly one cycle; exactly 4 pops observed.
- Backpressure: 8 bytes A0..A7 queued, out_ready=0 for 20 cycles → out_data=32'hA3A2A1A0 stable, fifo_rd_en=0 throughout HOLD. On release, second word is 32'hA7A6A5A4.
- Empty gaps: bytes B0..B3 written with 5+ idle cycles between each → single word 32'hB3B2B1B0. fifo_rd_en is never asserted while fifo_empty=1.
- Reset mid-fill: pop C0,C1, pulse rst one cycle, then push D0..D3 → out_data=32'hD3D2D1D0. C0/C1 never appear; all outputs 0 during reset.
- Flush (macro defined): push E0,E1,E2 then nothing → after 16 idle cycles out_valid=1, out_data=32'h00E2E1E0, out_count=3. Without the macro → out_valid stays 0 for 100 cycles.
- Simultaneous handshake and pending data: 12 bytes queued, out_ready=1 → three words, in order, no byte lost or duplicated.
